// File: rtl/slurm32_cpu_muldiv_if.sv
// Handshake/bus bundle for the iterative multiply/divide unit.
// master drives start/op/A/B/flags_en/abort; slave returns result, status and flags.
interface slurm32_cpu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             flags_en;
    logic             abort;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             C;
    logic             Z;
    logic             S;
    logic             V;

    modport master (
        output start, op, A, B, flags_en, abort,
        input  result, busy, done, C, Z, S, V
    );

    modport slave (
        input  start, op, A, B, flags_en, abort,
        output result, busy, done, C, Z, S, V
    );
endinterface

// File: rtl/slurm32_cpu_muldiv.sv
// Iterative radix-2 MUL/MULHU/DIVU/REMU unit with start/busy/done handshake
// and private flags. Ports: CLK, RSTb (async low), bus (slave side of _if).
module slurm32_cpu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RSTb,
    slurm32_cpu_muldiv_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_MUL,
        OP_MULHU,
        OP_DIVU,
        OP_REMU
    } op_t;

    state_t           state;
    op_t              op_q;
    logic             fen_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   shl;
    logic             ge;
    logic [WIDTH-1:0] res_fin;
    logic             v_fin;
    logic [WIDTH-1:0] res_dz;
    logic             accept;
    logic             dz;

    // One radix-2 step; both datapaths advance every RUN cycle and only
    // the one matching the latched op is selected at the end.
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + (acc[0] ? {1'b0, a_q} : '0);
        shl     = {rem[WIDTH-1:0], quo[WIDTH-1]};
        ge      = (shl >= {1'b0, b_q});
        res_fin = acc[WIDTH-1:0];
        v_fin   = 1'b0;
        unique case (op_q)
            OP_MUL: begin
                res_fin = acc[WIDTH-1:0];
                v_fin   = |acc[2*WIDTH-1:WIDTH];
            end
            OP_MULHU: res_fin = acc[2*WIDTH-1:WIDTH];
            OP_DIVU:  res_fin = quo;
            OP_REMU:  res_fin = rem[WIDTH-1:0];
            default:  res_fin = acc[WIDTH-1:0];
        endcase
    end

    // Divide-by-zero short-circuits straight to DONE from the request.
    assign accept = bus.start && !bus.abort;
    assign dz     = bus.op[1] && (bus.B == '0);
    assign res_dz = bus.op[0] ? bus.A : '1;

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state      <= ST_IDLE;
            op_q       <= OP_MUL;
            fen_q      <= 1'b0;
            cnt        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc        <= '0;
            rem        <= '0;
            quo        <= '0;
            bus.result <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.C      <= 1'b0;
            bus.Z      <= 1'b0;
            bus.S      <= 1'b0;
            bus.V      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    state <= ST_IDLE;
                    if (accept) begin
                        op_q  <= op_t'(bus.op);
                        fen_q <= bus.flags_en;
                        a_q   <= bus.A;
                        b_q   <= bus.B;
                        acc   <= {{WIDTH{1'b0}}, bus.B};
                        rem   <= '0;
                        quo   <= bus.A;
                        cnt   <= CW'(WIDTH);
                        if (dz) begin
                            state      <= ST_DONE;
                            bus.done   <= 1'b1;
                            bus.result <= res_dz;
                            if (bus.flags_en) begin
                                bus.C <= 1'b1;
                                bus.Z <= (res_dz == '0);
                                bus.S <= res_dz[WIDTH-1];
                                bus.V <= 1'b0;
                            end
                        end else begin
                            state    <= ST_RUN;
                            bus.busy <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end else if (cnt != '0) begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                        rem <= ge ? (shl - {1'b0, b_q}) : shl;
                        quo <= {quo[WIDTH-2:0], ge};
                        cnt <= cnt - CW'(1);
                    end else begin
                        state      <= ST_DONE;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        bus.result <= res_fin;
                        if (fen_q) begin
                            bus.C <= 1'b0;
                            bus.Z <= (res_fin == '0);
                            bus.S <= res_fin[WIDTH-1];
                            bus.V <= v_fin;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_slurm32_cpu_muldiv.sv
// Directed-vector bench for slurm32_cpu_muldiv at WIDTH=32 and WIDTH=8.
// Ports: none; drives two DUT instances through their interfaces.
module tb_slurm32_cpu_muldiv;
    logic CLK;
    logic RSTb;
    int   total;
    int   bad;

    slurm32_cpu_muldiv_if #(.WIDTH(32)) if32 ();
    slurm32_cpu_muldiv_if #(.WIDTH(8))  if8 ();

    slurm32_cpu_muldiv #(.WIDTH(32)) u32 (
        .CLK  (CLK),
        .RSTb (RSTb),
        .bus  (if32.slave)
    );

    slurm32_cpu_muldiv #(.WIDTH(8)) u8 (
        .CLK  (CLK),
        .RSTb (RSTb),
        .bus  (if8.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Launch one op on the 32-bit unit; n = edges from start edge to done.
    task automatic go32(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic fen,
                        output int n, output logic b0);
        if32.op = op;
        if32.A = a;
        if32.B = b;
        if32.flags_en = fen;
        if32.start = 1'b1;
        tick();
        if32.start = 1'b0;
        b0 = if32.busy;
        n = 0;
        while (!if32.done && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic go8(input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, output int n);
        if8.op = op;
        if8.A = a;
        if8.B = b;
        if8.flags_en = 1'b1;
        if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        n = 0;
        while (!if8.done && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        total++;
        if ({if32.busy, if32.done, if32.C, if32.Z, if32.S, if32.V} !== 6'b0
            || if32.result !== 32'h0) begin
            bad++;
            $display("FAIL reset32: got res=%h st=%b want 0", if32.result,
                     {if32.busy, if32.done, if32.C, if32.Z, if32.S, if32.V});
        end
        total++;
        if ({if8.busy, if8.done, if8.C, if8.Z, if8.S, if8.V} !== 6'b0
            || if8.result !== 8'h0) begin
            bad++;
            $display("FAIL reset8: got res=%h want 0", if8.result);
        end
    endtask

    task automatic test_mul_small();
        int n;
        logic b0;
        go32(2'd0, 32'd3, 32'd4, 1'b1, n, b0);
        total++;
        if (b0 !== 1'b1) begin
            bad++;
            $display("FAIL mul_busy: got %b want 1", b0);
        end
        total++;
        if (n !== 33) begin
            bad++;
            $display("FAIL mul_latency: got %0d want 33", n);
        end
        total++;
        if (if32.result !== 32'd12 || if32.busy !== 1'b0) begin
            bad++;
            $display("FAIL mul_result: got %h busy=%b want 0000000c busy=0",
                     if32.result, if32.busy);
        end
        total++;
        if ({if32.C, if32.Z, if32.S, if32.V} !== 4'b0000) begin
            bad++;
            $display("FAIL mul_flags: got %b want 0000",
                     {if32.C, if32.Z, if32.S, if32.V});
        end
        tick();
        total++;
        if (if32.done !== 1'b0) begin
            bad++;
            $display("FAIL mul_pulse: got done=%b want 0", if32.done);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic b0;
        go32(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, n, b0);
        total++;
        if (if32.result !== 32'h1 ||
            {if32.C, if32.Z, if32.S, if32.V} !== 4'b0001) begin
            bad++;
            $display("FAIL mul_ovf: got %h %b want 00000001 0001", if32.result,
                     {if32.C, if32.Z, if32.S, if32.V});
        end
        go32(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, n, b0);
        total++;
        if (b0 !== 1'b1 || n !== 33) begin
            bad++;
            $display("FAIL b2b_timing: got busy=%b n=%0d want 1 33", b0, n);
        end
        total++;
        if (if32.result !== 32'hFFFF_FFFE ||
            {if32.C, if32.Z, if32.S, if32.V} !== 4'b0010) begin
            bad++;
            $display("FAIL mulhu: got %h %b want fffffffe 0010", if32.result,
                     {if32.C, if32.Z, if32.S, if32.V});
        end
        tick();
    endtask

    task automatic test_div();
        int n;
        logic b0;
        go32(2'd2, 32'd100, 32'd7, 1'b1, n, b0);
        total++;
        if (if32.result !== 32'd14 || if32.Z !== 1'b0 || n !== 33) begin
            bad++;
            $display("FAIL divu_100_7: got %0d Z=%b n=%0d want 14 0 33",
                     if32.result, if32.Z, n);
        end
        tick();
        go32(2'd2, 32'd5, 32'd9, 1'b1, n, b0);
        total++;
        if (if32.result !== 32'd0 || if32.Z !== 1'b1) begin
            bad++;
            $display("FAIL divu_5_9: got %0d Z=%b want 0 1", if32.result, if32.Z);
        end
        tick();
        go32(2'd3, 32'd100, 32'd7, 1'b0, n, b0);
        total++;
        if (if32.result !== 32'd2 || if32.Z !== 1'b1) begin
            bad++;
            $display("FAIL remu_held: got %0d Z=%b want 2 1", if32.result, if32.Z);
        end
        tick();
    endtask

    task automatic test_div_zero();
        int n;
        logic b0;
        go32(2'd2, 32'd5, 32'd0, 1'b1, n, b0);
        total++;
        if (n !== 0 || b0 !== 1'b0) begin
            bad++;
            $display("FAIL dz_timing: got n=%0d busy=%b want 0 0", n, b0);
        end
        total++;
        if (if32.result !== 32'hFFFF_FFFF ||
            {if32.C, if32.Z, if32.S, if32.V} !== 4'b1010) begin
            bad++;
            $display("FAIL divu_dz: got %h %b want ffffffff 1010", if32.result,
                     {if32.C, if32.Z, if32.S, if32.V});
        end
        tick();
        go32(2'd3, 32'd5, 32'd0, 1'b1, n, b0);
        total++;
        if (if32.result !== 32'd5 || n !== 0 ||
            {if32.C, if32.Z, if32.S, if32.V} !== 4'b1000) begin
            bad++;
            $display("FAIL remu_dz: got %h n=%0d %b want 5 0 1000", if32.result,
                     n, {if32.C, if32.Z, if32.S, if32.V});
        end
        tick();
    endtask

    task automatic test_abort();
        int seen;
        int n;
        logic b0;
        if32.op = 2'd0;
        if32.A = 32'd6;
        if32.B = 32'd7;
        if32.flags_en = 1'b1;
        if32.start = 1'b1;
        tick();
        if32.start = 1'b0;
        repeat (9) tick();
        if32.abort = 1'b1;
        tick();
        if32.abort = 1'b0;
        total++;
        if (if32.busy !== 1'b0 || if32.done !== 1'b0) begin
            bad++;
            $display("FAIL abort_run: got busy=%b done=%b want 0 0",
                     if32.busy, if32.done);
        end
        seen = 0;
        repeat (40) begin
            tick();
            if (if32.done) seen++;
        end
        total++;
        if (seen !== 0 || if32.result !== 32'd5 ||
            {if32.C, if32.Z, if32.S, if32.V} !== 4'b1000) begin
            bad++;
            $display("FAIL abort_hold: got done_seen=%0d res=%h %b want 0 5 1000",
                     seen, if32.result, {if32.C, if32.Z, if32.S, if32.V});
        end
        if32.abort = 1'b1;
        if32.start = 1'b1;
        tick();
        if32.start = 1'b0;
        if32.abort = 1'b0;
        seen = 0;
        repeat (40) begin
            if (if32.busy || if32.done) seen++;
            tick();
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL abort_start: got active=%0d want 0", seen);
        end
        go32(2'd0, 32'd6, 32'd7, 1'b1, n, b0);
        total++;
        if (if32.result !== 32'd42 || n !== 33 ||
            {if32.C, if32.Z, if32.S, if32.V} !== 4'b0000) begin
            bad++;
            $display("FAIL mul_6_7: got %0d n=%0d %b want 42 33 0000",
                     if32.result, n, {if32.C, if32.Z, if32.S, if32.V});
        end
        tick();
    endtask

    task automatic test_start_ignored();
        int n;
        if32.op = 2'd0;
        if32.A = 32'd3;
        if32.B = 32'd5;
        if32.start = 1'b1;
        tick();
        if32.start = 1'b0;
        n = 0;
        repeat (5) begin
            tick();
            n++;
        end
        if32.op = 2'd2;
        if32.A = 32'd100;
        if32.B = 32'd7;
        if32.start = 1'b1;
        tick();
        n++;
        if32.start = 1'b0;
        while (!if32.done && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (n !== 33 || if32.result !== 32'd15) begin
            bad++;
            $display("FAIL start_ignored: got %0d n=%0d want 15 33",
                     if32.result, n);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        if32.op = 2'd0;
        if32.A = 32'd9;
        if32.B = 32'd9;
        if32.start = 1'b1;
        tick();
        if32.start = 1'b0;
        repeat (5) tick();
        #2;
        RSTb = 1'b0;
        #1;
        total++;
        if ({if32.busy, if32.done, if32.C, if32.Z, if32.S, if32.V} !== 6'b0
            || if32.result !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid: got res=%h st=%b want 0", if32.result,
                     {if32.busy, if32.done, if32.C, if32.Z, if32.S, if32.V});
        end
        RSTb = 1'b1;
        repeat (3) tick();
        total++;
        if (if32.busy !== 1'b0 || if32.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got busy=%b done=%b want 0 0",
                     if32.busy, if32.done);
        end
    endtask

    task automatic test_width8();
        int n;
        go8(2'd2, 8'd200, 8'd13, n);
        total++;
        if (if8.result !== 8'd15 || n !== 9) begin
            bad++;
            $display("FAIL w8_divu: got %0d n=%0d want 15 9", if8.result, n);
        end
        tick();
        go8(2'd3, 8'd200, 8'd13, n);
        total++;
        if (if8.result !== 8'd5) begin
            bad++;
            $display("FAIL w8_remu: got %0d want 5", if8.result);
        end
        tick();
        go8(2'd0, 8'h10, 8'h10, n);
        total++;
        if (if8.result !== 8'h00 ||
            {if8.C, if8.Z, if8.S, if8.V} !== 4'b0101) begin
            bad++;
            $display("FAIL w8_mul: got %h %b want 00 0101", if8.result,
                     {if8.C, if8.Z, if8.S, if8.V});
        end
        tick();
    endtask

    initial begin
        total = 0;
        bad = 0;
        RSTb = 1'b0;
        if32.start = 1'b0;
        if32.op = 2'd0;
        if32.A = '0;
        if32.B = '0;
        if32.flags_en = 1'b0;
        if32.abort = 1'b0;
        if8.start = 1'b0;
        if8.op = 2'd0;
        if8.A = '0;
        if8.B = '0;
        if8.flags_en = 1'b0;
        if8.abort = 1'b0;
        #12;
        test_reset();
        RSTb = 1'b1;
        tick();
        test_mul_small();
        test_back_to_back();
        test_div();
        test_div_zero();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        test_width8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
